clock_alarm_ctrl: RTL and testbench

- Mode controller for the wall clock and alarm.
- Owns the HH:MM:SS time-of-day registers and the alarm registers.
- Sequences set-time and set-alarm modes from debounced button pulses and raises the buzzer on an alarm match.
- Produces the 32-bit packed word consumed by the 7-segment multiplexer; sits between the button debouncers/1 Hz clock divider and the display decoder.

---
 rtl/clock_alarm_pkg.sv | 23 ++
 rtl/bcd2_counter.sv | 52 +++++
 rtl/clock_alarm_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_alarm_pkg.sv
// rtl/clock_alarm_pkg.sv - shared state encoding, BCD limits and reset constants for the alarm clock
// Mode codes double as state encoding; ST_SNOOZE exists only with CLOCK_ALARM_SNOOZE_EN.
package clock_alarm_pkg;

  localparam logic [2:0] ST_SHOW_TIME    = 3'd0;
  localparam logic [2:0] ST_SET_HOUR     = 3'd1;
  localparam logic [2:0] ST_SET_MIN      = 3'd2;
  localparam logic [2:0] ST_SET_ALM_HOUR = 3'd3;
  localparam logic [2:0] ST_SET_ALM_MIN  = 3'd4;
  localparam logic [2:0] ST_RING         = 3'd5;
  localparam logic [2:0] ST_SNOOZE       = 3'd6;

  localparam logic [7:0]  BLANK_BYTE   = 8'hFF;
  localparam logic [7:0]  BCD_MAX_HH   = 8'h23;
  localparam logic [7:0]  BCD_MAX_MM   = 8'h59;
  localparam logic [7:0]  RST_BCD_ZERO = 8'h00;
  localparam logic [31:0] RST_DISPLAY  = 32'h0000_0000;

  function automatic logic is_set_state(input logic [2:0] s);
    return (s >= ST_SET_HOUR) && (s <= ST_SET_ALM_MIN);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter wrapping at MAX, with clear and wrap pulse
// o_q_nxt exposes the next value so the parent can register derived outputs in the same edge.
module bcd2_counter
  import clock_alarm_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MAX_MM,
  parameter logic [7:0] RST = RST_BCD_ZERO
) (
  input  logic       clk,
  input  logic       Nreset,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] o_q,
  output logic [7:0] o_q_nxt,
  output logic       wrap
);

  logic [7:0] r_q;
  logic [7:0] w_step;

  always_comb begin
    if (r_q == MAX) begin
      w_step = 8'h00;
    end else if (r_q[3:0] == 4'd9) begin
      w_step = {r_q[7:4] + 4'd1, 4'd0};
    end else begin
      w_step = {r_q[7:4], r_q[3:0] + 4'd1};
    end
  end

  always_comb begin
    if (clr) begin
      o_q_nxt = 8'h00;
    end else if (inc) begin
      o_q_nxt = w_step;
    end else begin
      o_q_nxt = r_q;
    end
  end

  assign wrap = inc & (r_q == MAX);
  assign o_q  = r_q;

  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      r_q <= RST;
    end else begin
      r_q <= o_q_nxt;
    end
  end

endmodule

// File: rtl/clock_alarm_ctrl.sv
// rtl/clock_alarm_ctrl.sv - wall clock / alarm mode controller with registered display word
// Optional snooze state enabled by defining CLOCK_ALARM_SNOOZE_EN.
module clock_alarm_ctrl
  import clock_alarm_pkg::*;
#(
  parameter int         RING_SECS   = 60,
  parameter int         SNOOZE_SECS = 300,
  parameter logic [7:0] ALM_RST_HH  = 8'h07
) (
  input  logic        clk,
  input  logic        Nreset,
  input  logic        tick_1hz,
  input  logic        mode_p,
  input  logic        up_p,
  output logic [31:0] to_display,
  output logic        buzzer,
  output logic        alm_en
);

  localparam logic [7:0] RING_LOAD   = 8'(RING_SECS);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS);

  logic [2:0]  r_state, w_state_nxt;
  logic        r_alm_en, w_alm_en_nxt;
  logic        r_blink, w_blink_nxt;
  logic        r_buzzer;
  logic [7:0]  r_ring_cnt, w_ring_cnt_nxt;
  logic [31:0] r_disp, w_disp_nxt;

  logic [7:0] w_hr_q, w_hr_nxt, w_min_q, w_min_nxt, w_sec_q, w_sec_nxt;
  logic [7:0] w_ahr_q, w_ahr_nxt, w_amin_q, w_amin_nxt;
  logic       w_sec_wrap, w_min_wrap;
  logic [2:0] w_unused_wrap;
  logic [7:0] w_hh, w_mm, w_ss;

  // The clock stands still while its own fields are being edited.
  logic w_keep, w_up, w_sec_clr, w_sec_inc, w_min_inc, w_hr_inc, w_ahr_inc, w_amin_inc, w_match;
  assign w_keep     = tick_1hz & (r_state != ST_SET_HOUR) & (r_state != ST_SET_MIN);
  assign w_up       = up_p & ~mode_p;
  assign w_sec_clr  = (r_state == ST_SHOW_TIME) & mode_p;
  assign w_sec_inc  = w_keep;
  assign w_min_inc  = (w_keep & w_sec_wrap) | ((r_state == ST_SET_MIN) & w_up);
  assign w_hr_inc   = (w_keep & w_sec_wrap & w_min_wrap) | ((r_state == ST_SET_HOUR) & w_up);
  assign w_ahr_inc  = (r_state == ST_SET_ALM_HOUR) & w_up;
  assign w_amin_inc = (r_state == ST_SET_ALM_MIN) & w_up;

  bcd2_counter #(.MAX(BCD_MAX_MM), .RST(RST_BCD_ZERO)) u_sec (
    .clk(clk), .Nreset(Nreset), .inc(w_sec_inc), .clr(w_sec_clr),
    .o_q(w_sec_q), .o_q_nxt(w_sec_nxt), .wrap(w_sec_wrap));
  bcd2_counter #(.MAX(BCD_MAX_MM), .RST(RST_BCD_ZERO)) u_min (
    .clk(clk), .Nreset(Nreset), .inc(w_min_inc), .clr(1'b0),
    .o_q(w_min_q), .o_q_nxt(w_min_nxt), .wrap(w_min_wrap));
  bcd2_counter #(.MAX(BCD_MAX_HH), .RST(RST_BCD_ZERO)) u_hr (
    .clk(clk), .Nreset(Nreset), .inc(w_hr_inc), .clr(1'b0),
    .o_q(w_hr_q), .o_q_nxt(w_hr_nxt), .wrap(w_unused_wrap[2]));
  bcd2_counter #(.MAX(BCD_MAX_HH), .RST(ALM_RST_HH)) u_alm_hr (
    .clk(clk), .Nreset(Nreset), .inc(w_ahr_inc), .clr(1'b0),
    .o_q(w_ahr_q), .o_q_nxt(w_ahr_nxt), .wrap(w_unused_wrap[1]));
  bcd2_counter #(.MAX(BCD_MAX_MM), .RST(RST_BCD_ZERO)) u_alm_min (
    .clk(clk), .Nreset(Nreset), .inc(w_amin_inc), .clr(1'b0),
    .o_q(w_amin_q), .o_q_nxt(w_amin_nxt), .wrap(w_unused_wrap[0]));

  // Match is judged on the post-tick time but the pre-edge arming bit.
  assign w_match = (r_state == ST_SHOW_TIME) & r_alm_en & tick_1hz & ~mode_p &
                   (w_hr_nxt == w_ahr_q) & (w_min_nxt == w_amin_q) & (w_sec_nxt == 8'h00);

`ifdef CLOCK_ALARM_SNOOZE_EN
  logic [9:0] r_snz_cnt, w_snz_cnt_nxt;
`else
  logic w_unused_snooze;
  assign w_unused_snooze = ^SNOOZE_LOAD;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_alm_en_nxt   = r_alm_en;
    w_ring_cnt_nxt = r_ring_cnt;
`ifdef CLOCK_ALARM_SNOOZE_EN
    w_snz_cnt_nxt  = r_snz_cnt;
`endif
    case (r_state)
      ST_SHOW_TIME: begin
        if (mode_p) begin
          w_state_nxt = ST_SET_HOUR;
        end else begin
          if (up_p) w_alm_en_nxt = ~r_alm_en;
          if (w_match) begin
            w_state_nxt    = ST_RING;
            w_ring_cnt_nxt = RING_LOAD;
          end
        end
      end
      ST_SET_HOUR:     if (mode_p) w_state_nxt = ST_SET_MIN;
      ST_SET_MIN:      if (mode_p) w_state_nxt = ST_SET_ALM_HOUR;
      ST_SET_ALM_HOUR: if (mode_p) w_state_nxt = ST_SET_ALM_MIN;
      ST_SET_ALM_MIN:  if (mode_p) w_state_nxt = ST_SHOW_TIME;
      ST_RING: begin
`ifdef CLOCK_ALARM_SNOOZE_EN
        if (mode_p) begin
          w_state_nxt = ST_SHOW_TIME;
        end else if (up_p) begin
          w_state_nxt   = ST_SNOOZE;
          w_snz_cnt_nxt = SNOOZE_LOAD;
        end else if (tick_1hz) begin
`else
        if (mode_p | up_p) begin
          w_state_nxt = ST_SHOW_TIME;
        end else if (tick_1hz) begin
`endif
          if (r_ring_cnt <= 8'd1) begin
            w_state_nxt    = ST_SHOW_TIME;
            w_ring_cnt_nxt = 8'd0;
          end else begin
            w_ring_cnt_nxt = r_ring_cnt - 8'd1;
          end
        end
      end
`ifdef CLOCK_ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (mode_p) begin
          w_state_nxt = ST_SHOW_TIME;
        end else if (tick_1hz) begin
          if (r_snz_cnt <= 10'd1) begin
            w_state_nxt    = ST_RING;
            w_snz_cnt_nxt  = 10'd0;
            w_ring_cnt_nxt = RING_LOAD;
          end else begin
            w_snz_cnt_nxt = r_snz_cnt - 10'd1;
          end
        end
      end
`endif
      default: w_state_nxt = ST_SHOW_TIME;
    endcase
  end

  assign w_blink_nxt = (!is_set_state(w_state_nxt) || (w_state_nxt != r_state)) ? 1'b0 :
                       (tick_1hz ? ~r_blink : r_blink);

  always_comb begin
    w_hh = w_hr_nxt;
    w_mm = w_min_nxt;
    w_ss = w_sec_nxt;
    if ((w_state_nxt == ST_SET_ALM_HOUR) || (w_state_nxt == ST_SET_ALM_MIN)) begin
      w_hh = w_ahr_nxt;
      w_mm = w_amin_nxt;
      w_ss = 8'h00;
    end
    if (w_blink_nxt) begin
      if ((w_state_nxt == ST_SET_HOUR) || (w_state_nxt == ST_SET_ALM_HOUR)) w_hh = BLANK_BYTE;
      if ((w_state_nxt == ST_SET_MIN) || (w_state_nxt == ST_SET_ALM_MIN)) w_mm = BLANK_BYTE;
    end
    w_disp_nxt = {w_hh, w_mm, w_ss, 1'b0, w_state_nxt, 3'b000, w_alm_en_nxt};
  end

  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      r_state    <= ST_SHOW_TIME;
      r_alm_en   <= 1'b0;
      r_blink    <= 1'b0;
      r_buzzer   <= 1'b0;
      r_ring_cnt <= 8'd0;
      r_disp     <= RST_DISPLAY;
    end else begin
      r_state    <= w_state_nxt;
      r_alm_en   <= w_alm_en_nxt;
      r_blink    <= w_blink_nxt;
      r_buzzer   <= (w_state_nxt == ST_RING);
      r_ring_cnt <= w_ring_cnt_nxt;
      r_disp     <= w_disp_nxt;
    end
  end

`ifdef CLOCK_ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge Nreset) begin
    if (!Nreset) begin
      r_snz_cnt <= 10'd0;
    end else begin
      r_snz_cnt <= w_snz_cnt_nxt;
    end
  end
`endif

  assign to_display = r_disp;
  assign buzzer     = r_buzzer;
  assign alm_en     = r_alm_en;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// tb/tb_clock_alarm_ctrl.sv - directed and random checks of clock_alarm_ctrl against a seconds-of-day model
// Honours CLOCK_ALARM_SNOOZE_EN for the snooze branch of the ring test.
module tb_clock_alarm_ctrl;

  localparam int RING_S   = 60;
  localparam int SNOOZE_S = 300;

  logic        clk = 1'b0;
  logic        Nreset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        mode_p = 1'b0;
  logic        up_p = 1'b0;
  logic [31:0] to_display;
  logic        buzzer;
  logic        alm_en;

  int total = 0;
  int bad   = 0;

  int m_st, m_t, m_ah, m_am, m_ring;
  bit m_en, m_blink;
`ifdef CLOCK_ALARM_SNOOZE_EN
  int m_snz;
`endif

  always #5 clk = ~clk;

  clock_alarm_ctrl #(.RING_SECS(RING_S), .SNOOZE_SECS(SNOOZE_S), .ALM_RST_HH(8'h07)) dut (
    .clk(clk), .Nreset(Nreset), .tick_1hz(tick_1hz), .mode_p(mode_p), .up_p(up_p),
    .to_display(to_display), .buzzer(buzzer), .alm_en(alm_en));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_set(input int s);
    return (s >= 1) && (s <= 4);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic logic [31:0] m_disp();
    logic [7:0] hh, mm, ss;
    if (m_st == 3 || m_st == 4) begin
      hh = bcd(m_ah); mm = bcd(m_am); ss = 8'h00;
    end else begin
      hh = bcd(m_t / 3600); mm = bcd((m_t / 60) % 60); ss = bcd(m_t % 60);
    end
    if (m_blink && (m_st == 1 || m_st == 3)) hh = 8'hFF;
    if (m_blink && (m_st == 2 || m_st == 4)) mm = 8'hFF;
    return {hh, mm, ss, 4'(m_st), 3'b000, m_en};
  endfunction

  task automatic m_reset();
    m_st = 0; m_t = 0; m_ah = 7; m_am = 0; m_en = 0; m_blink = 0; m_ring = 0;
`ifdef CLOCK_ALARM_SNOOZE_EN
    m_snz = 0;
`endif
  endtask

  task automatic m_step(input bit t, input bit m, input bit u);
    int ost, nst, h, mi;
    ost = m_st;
    nst = m_st;
    if (t && ost != 1 && ost != 2) m_t = (m_t + 1) % 86400;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    case (ost)
      0: if (m) begin
           nst = 1;
           m_t = m_t - (m_t % 60);
         end else begin
           if (t && m_en && m_t == m_ah * 3600 + m_am * 60) begin
             nst = 5; m_ring = RING_S;
           end
           if (u) m_en = !m_en;
         end
      1: if (m) nst = 2; else if (u) m_t = ((h + 1) % 24) * 3600 + mi * 60 + m_t % 60;
      2: if (m) nst = 3; else if (u) m_t = h * 3600 + ((mi + 1) % 60) * 60 + m_t % 60;
      3: if (m) nst = 4; else if (u) m_ah = (m_ah + 1) % 24;
      4: if (m) nst = 0; else if (u) m_am = (m_am + 1) % 60;
      5: begin
`ifdef CLOCK_ALARM_SNOOZE_EN
        if (m) nst = 0;
        else if (u) begin nst = 6; m_snz = SNOOZE_S; end
`else
        if (m || u) nst = 0;
`endif
        else if (t) begin
          m_ring--;
          if (m_ring == 0) nst = 0;
        end
      end
`ifdef CLOCK_ALARM_SNOOZE_EN
      6: if (m) nst = 0;
         else if (t) begin
           m_snz--;
           if (m_snz == 0) begin nst = 5; m_ring = RING_S; end
         end
`endif
      default: nst = 0;
    endcase
    if (!is_set(nst) || nst != ost) m_blink = 0;
    else if (t) m_blink = !m_blink;
    m_st = nst;
  endtask

  task automatic cyc(input bit t, input bit m, input bit u);
    tick_1hz = t; mode_p = m; up_p = u;
    @(posedge clk);
    m_step(t, m, u);
    #1;
    tick_1hz = 0; mode_p = 0; up_p = 0;
    chk("disp", to_display, m_disp());
    chk("buzzer", {31'b0, buzzer}, {31'b0, m_st == 5});
    chk("alm_en", {31'b0, alm_en}, {31'b0, m_en});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0);
  endtask

  task automatic press_up(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  // Sets the alarm to the minute after the current time, then ticks up to it.
  task automatic ring_next_minute();
    int tgt;
    press_mode(3);
    tgt = (m_t / 60 + 1) % 1440;
    for (int i = 0; i < 24 && m_ah != tgt / 60; i++) cyc(0, 0, 1);
    press_mode(1);
    for (int i = 0; i < 60 && m_am != tgt % 60; i++) cyc(0, 0, 1);
    press_mode(1);
    ticks(60);
    chk("ring_buzzer", {31'b0, buzzer}, 32'd1);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_disp", to_display, 32'h0000_0000);
    chk("rst_buzzer", {31'b0, buzzer}, 32'd0);
    chk("rst_alm_en", {31'b0, alm_en}, 32'd0);
    #2 Nreset = 1'b1;

    ticks(61);
    chk("t61_disp", to_display, 32'h0001_0100);
    chk("t61_buzzer", {31'b0, buzzer}, 32'd0);

    press_mode(1); press_up(23);
    press_mode(1); press_up(58);
    press_mode(3);
    ticks(59);
    chk("t235959", {8'h00, to_display[31:8]}, 32'h0023_5959);
    ticks(1);
    chk("midnight", {8'h00, to_display[31:8]}, 32'h0000_0000);

    press_mode(1); press_up(3);
    chk("sethour_hh", {24'h0, to_display[31:24]}, 32'h03);
    chk("sethour_code", {28'h0, to_display[7:4]}, 32'd1);
    ticks(1);
    chk("blink_hh", {24'h0, to_display[31:24]}, 32'hFF);
    ticks(1);
    chk("hold_hh", {24'h0, to_display[31:24]}, 32'h03);
    press_mode(4);
    chk("back_code", {28'h0, to_display[7:4]}, 32'd0);

    press_mode(1); press_up(3);
    press_mode(1); press_up(59);
    press_mode(3);
    press_up(1);
    chk("armed", {31'b0, alm_en}, 32'd1);
    ticks(59);
    chk("t065959", {8'h00, to_display[31:8]}, 32'h0006_5959);
    ticks(1);
    chk("alarm_buzzer", {31'b0, buzzer}, 32'd1);
    chk("alarm_code", {28'h0, to_display[7:4]}, 32'd5);
    ticks(59);
    chk("still_ringing", {31'b0, buzzer}, 32'd1);
    ticks(1);
    chk("timeout_buzzer", {31'b0, buzzer}, 32'd0);
    chk("timeout_code", {28'h0, to_display[7:4]}, 32'd0);
    chk("timeout_alm_en", {31'b0, alm_en}, 32'd1);

    ring_next_minute();
    press_up(1);
`ifdef CLOCK_ALARM_SNOOZE_EN
    chk("snooze_code", {28'h0, to_display[7:4]}, 32'd6);
    chk("snooze_buzzer", {31'b0, buzzer}, 32'd0);
    ticks(SNOOZE_S - 1);
    chk("snooze_hold", {28'h0, to_display[7:4]}, 32'd6);
    ticks(1);
    chk("rering_code", {28'h0, to_display[7:4]}, 32'd5);
    chk("rering_buzzer", {31'b0, buzzer}, 32'd1);
    press_mode(1);
    chk("snz_dismiss_code", {28'h0, to_display[7:4]}, 32'd0);
`else
    chk("dismiss_buzzer", {31'b0, buzzer}, 32'd0);
    chk("dismiss_code", {28'h0, to_display[7:4]}, 32'd0);
    chk("dismiss_alm_en", {31'b0, alm_en}, 32'd1);
`endif

    cyc(0, 1, 1);
    chk("both_code", {28'h0, to_display[7:4]}, 32'd1);
    chk("both_alm_en", {31'b0, alm_en}, 32'd1);
    press_mode(4);

    ring_next_minute();
    #2 Nreset = 1'b0;
    #1;
    chk("async_buzzer", {31'b0, buzzer}, 32'd0);
    chk("async_disp", to_display, 32'h0000_0000);
    chk("async_alm_en", {31'b0, alm_en}, 32'd0);
    m_reset();
    #2 Nreset = 1'b1;
    cyc(0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
